// File: rtl/bank_collision_arbiter.sv
// Multi-bank collision detector/arbiter: one grant per bank, per-agent loser flags, saturating event counter.
// Optional macro BANK_RR_EN selects per-bank round-robin pointers; otherwise the lowest index wins.

module bank_collision_arbiter_bank #(
  parameter int NB_AGENT = 4,
  parameter int AW       = 2
) (
  input  logic [NB_AGENT-1:0] rmask,
  input  logic [AW-1:0]       ptr,
  output logic [NB_AGENT-1:0] gnt,
  output logic [NB_AGENT-1:0] lose
);
  logic found;
  int   idx;

  // First requester at or after ptr, wrapping modulo NB_AGENT.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NB_AGENT; k++) begin
      idx = (int'(ptr) + k) % NB_AGENT;
      if (!found && rmask[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
      end
    end
  end

  // Losers only exist when two or more agents share the bank.
  assign lose = (|(rmask & (rmask - NB_AGENT'(1)))) ? (rmask & ~gnt) : '0;
endmodule

module bank_collision_arbiter #(
  parameter int NB_AGENT     = 4,
  parameter int NB_BANK      = 4,
  parameter int SELECT_WIDTH = $clog2(NB_BANK),
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             aclk,
  input  logic                             srst,
  input  logic [NB_AGENT-1:0]              req,
  input  logic [NB_AGENT*SELECT_WIDTH-1:0] bank_select,
  input  logic                             cnt_clear,
  output logic [NB_AGENT-1:0]              grant,
  output logic [NB_AGENT-1:0]              collision_vec,
  output logic                             collision,
  output logic [CNT_WIDTH-1:0]             collision_cnt,
  output logic [NB_AGENT-1:0]              err_oob
);
  localparam int AW = $clog2(NB_AGENT);

  logic [NB_BANK-1:0][NB_AGENT-1:0] rmask, gnt_b, lose_b;
  logic [NB_BANK-1:0][AW-1:0]       ptr;
  logic [NB_AGENT-1:0]              oob_nxt, grant_nxt, coll_nxt;
  logic [SELECT_WIDTH-1:0]          sel;

  always_comb begin
    rmask   = '0;
    oob_nxt = '0;
    sel     = '0;
    for (int i = 0; i < NB_AGENT; i++) begin
      sel = bank_select[i*SELECT_WIDTH +: SELECT_WIDTH];
      if (req[i] && int'(sel) >= NB_BANK) oob_nxt[i] = 1'b1;
      for (int b = 0; b < NB_BANK; b++)
        if (req[i] && int'(sel) == b) rmask[b][i] = 1'b1;
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < NB_BANK; gb++) begin : g_bank
      bank_collision_arbiter_bank #(.NB_AGENT(NB_AGENT), .AW(AW)) u_bank (
        .rmask (rmask[gb]),
        .ptr   (ptr[gb]),
        .gnt   (gnt_b[gb]),
        .lose  (lose_b[gb])
      );
    end
  endgenerate

  // Each agent sits in at most one bank, so OR-merging is collision-free.
  always_comb begin
    grant_nxt = '0;
    coll_nxt  = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      grant_nxt = grant_nxt | gnt_b[b];
      coll_nxt  = coll_nxt | lose_b[b];
    end
  end

`ifdef BANK_RR_EN
  function automatic logic [AW-1:0] after_winner(input logic [NB_AGENT-1:0] g);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < NB_AGENT; i++)
      if (g[i]) r = (i == NB_AGENT-1) ? '0 : AW'(i + 1);
    return r;
  endfunction

  always_ff @(posedge aclk) begin
    if (srst) begin
      ptr <= '0;
    end else begin
      for (int b = 0; b < NB_BANK; b++)
        if (|rmask[b]) ptr[b] <= after_winner(gnt_b[b]);
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge aclk) begin
    if (srst) begin
      grant         <= '0;
      collision_vec <= '0;
      collision     <= 1'b0;
      err_oob       <= '0;
      collision_cnt <= '0;
    end else begin
      grant         <= grant_nxt;
      collision_vec <= coll_nxt;
      collision     <= |coll_nxt;
      err_oob       <= oob_nxt;
      if (cnt_clear)
        collision_cnt <= '0;
      else if (|coll_nxt && collision_cnt != '1)
        collision_cnt <= collision_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_bank_collision_arbiter.sv
// Directed bench for bank_collision_arbiter with 4 agents, 3 banks and a 4-bit counter.
module tb_bank_collision_arbiter;
  logic       aclk = 1'b0;
  logic       srst;
  logic [3:0] req;
  logic [7:0] bank_select;
  logic       cnt_clear;
  logic [3:0] grant, collision_vec, err_oob, cnt;
  logic       collision;
  int         total = 0;
  int         bad   = 0;

  bank_collision_arbiter #(.NB_AGENT(4), .NB_BANK(3), .SELECT_WIDTH(2), .CNT_WIDTH(4)) dut (
    .aclk          (aclk),
    .srst          (srst),
    .req           (req),
    .bank_select   (bank_select),
    .cnt_clear     (cnt_clear),
    .grant         (grant),
    .collision_vec (collision_vec),
    .collision     (collision),
    .collision_cnt (cnt),
    .err_oob       (err_oob)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] cv,
                         input logic c, input logic [3:0] n, input logic [3:0] o);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".cvec"},  32'(collision_vec), 32'(cv));
    chk({tag, ".coll"},  32'(collision), 32'(c));
    chk({tag, ".cnt"},   32'(cnt), 32'(n));
    chk({tag, ".oob"},   32'(err_oob), 32'(o));
  endtask

  // Apply one cycle of inputs and sample 1 time unit after the edge.
  task automatic cyc(input logic [3:0] r, input logic [1:0] s0, input logic [1:0] s1,
                     input logic [1:0] s2, input logic [1:0] s3);
    req         = r;
    bank_select = {s3, s2, s1, s0};
    @(posedge aclk);
    #1;
  endtask

  logic [3:0] exp_g;

  initial begin
    srst = 1'b1; cnt_clear = 1'b0;
    cyc(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    cyc(4'b1111, 2'd0, 2'd0, 2'd0, 2'd0);
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 4'd0, 4'b0000);
    srst = 1'b0;

    // Four agents fight over bank 2 for four cycles.
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 2'd2, 2'd2, 2'd2, 2'd2);
`ifdef BANK_RR_EN
      exp_g = 4'b0001 << k;
`else
      exp_g = 4'b0001;
`endif
      chk_all($sformatf("contend%0d", k), exp_g, ~exp_g, 1'b1, 4'(k + 1), 4'b0000);
    end

    cyc(4'b0011, 2'd1, 2'd2, 2'd0, 2'd0);
    chk_all("single_hit", 4'b0011, 4'b0000, 1'b0, 4'd4, 4'b0000);

    cyc(4'b0100, 2'd0, 2'd0, 2'd3, 2'd0);
    chk_all("oob", 4'b0000, 4'b0000, 1'b0, 4'd4, 4'b0100);

    cyc(4'b0000, 2'd3, 2'd3, 2'd3, 2'd3);
    chk_all("idle", 4'b0000, 4'b0000, 1'b0, 4'd4, 4'b0000);

    // Agents 0,1 collide on bank 0, agent 2 out of range, agent 3 alone on bank 1.
    cyc(4'b1111, 2'd0, 2'd0, 2'd3, 2'd1);
    chk_all("mixed", 4'b1001, 4'b0010, 1'b1, 4'd5, 4'b0000 | 4'b0100);

    for (int k = 0; k < 20; k++) begin
      cyc(4'b0011, 2'd0, 2'd0, 2'd0, 2'd0);
      if (k == 9) chk("sat_reach", 32'(cnt), 32'd15);
    end
    chk("sat_hold", 32'(cnt), 32'd15);
    chk("sat_coll", 32'(collision), 32'd1);
    chk("sat_cvec_pop", 32'($countones(collision_vec)), 32'd1);

    cnt_clear = 1'b1;
    cyc(4'b0011, 2'd0, 2'd0, 2'd0, 2'd0);
    chk("clear_cnt", 32'(cnt), 32'd0);
    chk("clear_coll", 32'(collision), 32'd1);
    cnt_clear = 1'b0;
    cyc(4'b1100, 2'd0, 2'd0, 2'd1, 2'd1);
    chk("after_clear_cnt", 32'(cnt), 32'd1);
`ifdef BANK_RR_EN
    chk("after_clear_grant", 32'(grant), 32'b0100);
`else
    chk("after_clear_grant", 32'(grant), 32'b0100);
`endif
    chk("after_clear_cvec", 32'(collision_vec), 32'b1000);

    cyc(4'b0000, 2'd0, 2'd0, 2'd0, 2'd0);
    chk_all("idle2", 4'b0000, 4'b0000, 1'b0, 4'd1, 4'b0000);

    srst = 1'b1; cnt_clear = 1'b0;
    cyc(4'b1111, 2'd0, 2'd0, 2'd3, 2'd0);
    chk_all("reset2", 4'b0000, 4'b0000, 1'b0, 4'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
